// File: rtl/delay_sched_pkg.sv
// Shared types and widths for the delay event scheduler.
package delay_sched_pkg;

   localparam int unsigned SCHED_DW = 8;
   localparam int unsigned TBW      = SCHED_DW + 1;

   typedef enum logic {
      MODE_INERTIAL  = 1'b0,
      MODE_TRANSPORT = 1'b1
   } mode_e;

   typedef struct packed {
      logic           val;
      logic [TBW-1:0] ts;
   } event_t;

endpackage

// File: rtl/delay_channel.sv
// One scheduler channel: change detection, inertial pending slot, transport
// event FIFO, and the per-channel mode/delay configuration.
module delay_channel
   import delay_sched_pkg::*;
#(
   parameter int unsigned DW = SCHED_DW,
   parameter int unsigned QD = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [TBW-1:0] tb_next,
   input  logic           cfg_we,
   input  logic [DW-1:0]  cfg_delay,
   input  logic           cfg_mode,
   input  logic           inp,
   output logic           outp,
   output logic           drop_pulse,
   output logic           q_overflow,
   output logic           busy
);

   localparam int unsigned PW = (QD > 1) ? $clog2(QD) : 1;
   localparam int unsigned CW = $clog2(QD + 1);

   mode_e         mode_q, mode_d;
   logic [DW-1:0] delay_q, delay_d;
   logic          last_in_q, last_in_d;
   logic          outp_d, drop_d, ovf_d, busy_d;

   logic          slot_valid_q, slot_valid_d;
   logic          slot_val_q, slot_val_d;
   logic [DW-1:0] slot_cnt_q, slot_cnt_d;

   event_t        fifo_q [QD];
   event_t        fifo_d [QD];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          change, fire, out_now, pop, push;
   event_t        head;

   // Next-state for slot, FIFO and flags; a config write overrides everything.
   always_comb begin
      mode_d       = mode_q;
      delay_d      = delay_q;
      last_in_d    = last_in_q;
      outp_d       = outp;
      drop_d       = 1'b0;
      ovf_d        = q_overflow;
      slot_valid_d = slot_valid_q;
      slot_val_d   = slot_val_q;
      slot_cnt_d   = slot_cnt_q;
      fifo_d       = fifo_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      cnt_d        = cnt_q;
      fire         = 1'b0;
      out_now      = outp;
      pop          = 1'b0;
      push         = 1'b0;
      head         = fifo_q[rd_q];
      change       = (inp != last_in_q);

      if (cfg_we) begin
         mode_d       = mode_e'(cfg_mode);
         delay_d      = (cfg_delay == '0) ? DW'(1) : cfg_delay;
         slot_valid_d = 1'b0;
         rd_d         = '0;
         wr_d         = '0;
         cnt_d        = '0;
         last_in_d    = outp;
         ovf_d        = 1'b0;
      end else if (mode_q == MODE_INERTIAL) begin
         last_in_d = inp;
         fire      = slot_valid_q && (slot_cnt_q == '0);
         if (fire) begin
            outp_d       = slot_val_q;
            out_now      = slot_val_q;
            slot_valid_d = 1'b0;
         end else if (slot_valid_q) begin
            slot_cnt_d = slot_cnt_q - DW'(1);
         end
         // A change compares against the level the output holds after this edge.
         if (change) begin
            if (inp == out_now) begin
               slot_valid_d = 1'b0;
               drop_d       = slot_valid_q && !fire;
            end else begin
               slot_valid_d = 1'b1;
               slot_val_d   = inp;
               slot_cnt_d   = delay_q - DW'(1);
            end
         end
      end else begin
         last_in_d = inp;
         pop  = (cnt_q != '0) && (head.ts == tb_next);
         push = change && ((cnt_q != CW'(QD)) || pop);
         if (pop) begin
            outp_d = head.val;
            rd_d   = (rd_q == PW'(QD - 1)) ? '0 : rd_q + PW'(1);
         end
         if (push) begin
            fifo_d[wr_q] = '{val: inp, ts: tb_next + TBW'(delay_q)};
            wr_d         = (wr_q == PW'(QD - 1)) ? '0 : wr_q + PW'(1);
         end
         if (change && !push) begin
            ovf_d = 1'b1;
         end
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end

      busy_d = slot_valid_d | (cnt_d != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q       <= MODE_INERTIAL;
         delay_q      <= DW'(1);
         last_in_q    <= 1'b0;
         outp         <= 1'b0;
         drop_pulse   <= 1'b0;
         q_overflow   <= 1'b0;
         busy         <= 1'b0;
         slot_valid_q <= 1'b0;
         slot_val_q   <= 1'b0;
         slot_cnt_q   <= '0;
         rd_q         <= '0;
         wr_q         <= '0;
         cnt_q        <= '0;
         for (int i = 0; i < QD; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         mode_q       <= mode_d;
         delay_q      <= delay_d;
         last_in_q    <= last_in_d;
         outp         <= outp_d;
         drop_pulse   <= drop_d;
         q_overflow   <= ovf_d;
         busy         <= busy_d;
         slot_valid_q <= slot_valid_d;
         slot_val_q   <= slot_val_d;
         slot_cnt_q   <= slot_cnt_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         cnt_q        <= cnt_d;
         fifo_q       <= fifo_d;
      end
   end

endmodule

// File: rtl/delay_event_scheduler.sv
// Multi-channel delay scheduler: shared timebase, config decode and one
// delay_channel per input bit.
module delay_event_scheduler
   import delay_sched_pkg::*;
#(
   parameter  int unsigned NCH = 4,
   parameter  int unsigned DW  = SCHED_DW,
   parameter  int unsigned QD  = 4,
   localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_we,
   input  logic [CHW-1:0]  cfg_ch,
   input  logic [DW-1:0]   cfg_delay,
   input  logic            cfg_mode,
   input  logic [NCH-1:0]  inp,
   output logic [NCH-1:0]  outp,
   output logic [NCH-1:0]  drop_pulse,
   output logic [NCH-1:0]  q_overflow,
   output logic [NCH-1:0]  busy
);

   logic [TBW-1:0] tb_q;
   logic [TBW-1:0] tb_next;

   assign tb_next = tb_q + TBW'(1);

   // Free-running, wrapping timebase; events are stamped against its next value.
   always_ff @(posedge clk) begin
      if (rst) begin
         tb_q <= '0;
      end else begin
         tb_q <= tb_next;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic ch_we;
      assign ch_we = cfg_we && (cfg_ch == CHW'(i));

      delay_channel #(
         .DW (DW),
         .QD (QD)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .tb_next    (tb_next),
         .cfg_we     (ch_we),
         .cfg_delay  (cfg_delay),
         .cfg_mode   (cfg_mode),
         .inp        (inp[i]),
         .outp       (outp[i]),
         .drop_pulse (drop_pulse[i]),
         .q_overflow (q_overflow[i]),
         .busy       (busy[i])
      );
   end

endmodule

// File: tb/tb_delay_event_scheduler.sv
// Scoreboard bench: an edge-numbered reference model predicts every cycle's
// outputs; a monitor compares them against the scheduler.
module tb_delay_event_scheduler;

   localparam int NCH = 4;
   localparam int QD  = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           cfg_we = 1'b0;
   logic [1:0]     cfg_ch = '0;
   logic [7:0]     cfg_delay = '0;
   logic           cfg_mode = 1'b0;
   logic [NCH-1:0] inp = '0;
   logic [NCH-1:0] outp, drop_pulse, q_overflow, busy;

   always #5 clk = ~clk;

   delay_event_scheduler dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_delay  (cfg_delay),
      .cfg_mode   (cfg_mode),
      .inp        (inp),
      .outp       (outp),
      .drop_pulse (drop_pulse),
      .q_overflow (q_overflow),
      .busy       (busy)
   );

   typedef struct {
      logic [NCH-1:0] outp;
      logic [NCH-1:0] drop;
      logic [NCH-1:0] ovf;
      logic [NCH-1:0] busy;
   } exp_t;

   typedef struct {
      int ch;
      int due;
      bit val;
   } tev_t;

   exp_t exp_q[$];
   tev_t tq[$];

   bit m_mode [NCH];
   int m_d    [NCH];
   bit m_last [NCH];
   bit m_out  [NCH];
   bit m_ovf  [NCH];
   bit p_v    [NCH];
   bit p_val  [NCH];
   int p_due  [NCH];

   int n_edge = 0;
   int mon_n  = 0;
   int checks = 0;
   int fails  = 0;

   function automatic int tq_count(int c);
      int k = 0;
      foreach (tq[i]) if (tq[i].ch == c) k++;
      return k;
   endfunction

   function automatic int tq_head(int c);
      foreach (tq[i]) if (tq[i].ch == c) return i;
      return -1;
   endfunction

   task automatic tq_flush(int c);
      tev_t keep[$];
      foreach (tq[i]) if (tq[i].ch != c) keep.push_back(tq[i]);
      tq = keep;
   endtask

   // Reference: absolute edge numbers, delay D means "output lands D edges later".
   task automatic model_edge(bit r, bit we, int ch, int dly, bit md, logic [NCH-1:0] in);
      exp_t e;
      n_edge++;
      e.drop = '0;
      if (r) begin
         tq.delete();
         for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 0; m_d[c] = 1; m_last[c] = 0; m_out[c] = 0;
            m_ovf[c] = 0; p_v[c] = 0; p_val[c] = 0; p_due[c] = 0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (we && ch == c) begin
               m_mode[c] = md;
               m_d[c]    = (dly == 0) ? 1 : dly;
               p_v[c]    = 0;
               tq_flush(c);
               m_last[c] = m_out[c];
               m_ovf[c]  = 0;
            end else begin
               bit chg = (in[c] != m_last[c]);
               m_last[c] = in[c];
               if (!m_mode[c]) begin
                  if (p_v[c] && p_due[c] == n_edge) begin
                     m_out[c] = p_val[c];
                     p_v[c]   = 0;
                  end
                  if (chg) begin
                     if (in[c] == m_out[c]) begin
                        e.drop[c] = p_v[c];
                        p_v[c]    = 0;
                     end else begin
                        p_v[c]   = 1;
                        p_val[c] = in[c];
                        p_due[c] = n_edge + m_d[c];
                     end
                  end
               end else begin
                  int h = tq_head(c);
                  if (h >= 0 && tq[h].due == n_edge) begin
                     m_out[c] = tq[h].val;
                     tq.delete(h);
                  end
                  if (chg) begin
                     if (tq_count(c) < QD) tq.push_back('{ch: c, due: n_edge + m_d[c], val: in[c]});
                     else m_ovf[c] = 1;
                  end
               end
            end
         end
      end
      for (int c = 0; c < NCH; c++) begin
         e.outp[c] = m_out[c];
         e.ovf[c]  = m_ovf[c];
         e.busy[c] = p_v[c] || (tq_count(c) > 0);
      end
      exp_q.push_back(e);
   endtask

   task automatic tick(bit r, bit we, int ch, int dly, bit md, logic [NCH-1:0] in);
      @(negedge clk);
      rst       = r;
      cfg_we    = we;
      cfg_ch    = 2'(ch);
      cfg_delay = 8'(dly);
      cfg_mode  = md;
      inp       = in;
      model_edge(r, we, ch, dly, md, in);
   endtask

   task automatic idle(int cyc, logic [NCH-1:0] in);
      for (int i = 0; i < cyc; i++) tick(0, 0, 0, 0, 0, in);
   endtask

   task automatic chk(string nm, logic [NCH-1:0] act, logic [NCH-1:0] expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s at edge %0d: got %b, expected %b", nm, mon_n, act, expv);
      end
   endtask

   // Monitor: one expectation per clock edge, sampled just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            mon_n++;
            chk("outp", outp, e.outp);
            chk("drop_pulse", drop_pulse, e.drop);
            chk("q_overflow", q_overflow, e.ovf);
            chk("busy", busy, e.busy);
         end
      end
   end

   initial begin
      logic [NCH-1:0] cur;
      int dens;

      repeat (3) tick(1, 0, 0, 0, 0, '0);

      // ch0 inertial 3, ch1 inertial 5, ch2 transport 5, ch3 transport 20
      tick(0, 1, 0, 3, 0, '0);
      tick(0, 1, 1, 5, 0, '0);
      tick(0, 1, 2, 5, 1, '0);
      tick(0, 1, 3, 20, 1, '0);
      idle(2, '0);

      // 4-cycle pulse on ch0..2 while ch3 toggles six times into a 4-deep queue
      cur = '0;
      for (int k = 0; k < 6; k++) begin
         cur[2:0] = (k < 4) ? 3'b111 : 3'b000;
         cur[3]   = ~cur[3];
         tick(0, 0, 0, 0, 0, cur);
      end
      idle(30, cur);
      tick(0, 1, 3, 20, 1, cur);
      idle(2, cur);

      // Reconfigure while an inertial event is pending; input is re-detected
      tick(0, 1, 0, 10, 0, '0);
      tick(0, 0, 0, 0, 0, 4'b0001);
      tick(0, 0, 0, 0, 0, 4'b0001);
      tick(0, 1, 0, 2, 0, 4'b0001);
      idle(5, 4'b0001);
      idle(4, '0);

      // Pending events everywhere, then a one-cycle reset
      tick(0, 1, 0, 6, 0, '0);
      tick(0, 1, 1, 6, 1, '0);
      tick(0, 1, 2, 9, 0, '0);
      tick(0, 1, 3, 3, 1, '0);
      tick(0, 0, 0, 0, 0, 4'b1111);
      tick(0, 0, 0, 0, 0, 4'b0101);
      tick(1, 0, 0, 0, 0, 4'b0101);
      idle(12, 4'b0101);

      // Randomized traffic, long enough to wrap the timebase
      cur  = 4'b0101;
      dens = 2;
      for (int i = 0; i < 1500; i++) begin
         bit r, we, md;
         int ch, dly, sel;
         logic [NCH-1:0] nxt;
         if (i % 100 == 0) dens = $urandom_range(0, 7);
         r   = ($urandom_range(0, 299) == 0);
         we  = ($urandom_range(0, 19) == 0);
         ch  = $urandom_range(0, 3);
         sel = $urandom_range(0, 9);
         dly = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(200, 255) : $urandom_range(1, 8);
         md  = 1'($urandom_range(0, 1));
         nxt = cur;
         for (int c = 0; c < NCH; c++)
            if ($urandom_range(0, dens) == 0) nxt[c] = ~nxt[c];
         tick(r, we, ch, dly, md, nxt);
         cur = nxt;
      end
      idle(3, cur);

      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
